route_sched: RTL
================

Name: route_sched

Overview:
- Per-layer sequencer for the route (channel-concat/reorg) datapath.
- Accepts layer descriptors (output row count, output channel count) from the layer-control front end and validates them.
- Drives the route block's register inputs, Next_Reg and Start.
- Tracks output-stream beats and completion, then reports done or error per layer to the top-level scheduler.

Parameters:
- WIDTH_FEATURE_SIZE, 12, width of row-count fields.
- WIDTH_CHANNEL_NUM_REG, 11, width of channel-count fields.
- TIMEOUT_CYCLES, 65535, consecutive RUN cycles without an output beat before a timeout error is raised.
- WIDTH_LAYER_CNT, 8, width of the completed-layer counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- cmd_valid  in  1  descriptor valid
- cmd_ready  out  1  descriptor accept
- cmd_row  in  WIDTH_FEATURE_SIZE  output rows (= columns) for the layer
- cmd_ch  in  WIDTH_CHANNEL_NUM_REG  output channel count for the layer
- route_row_reg  out  WIDTH_FEATURE_SIZE  to route Row_Num_Out_REG
- route_ch_reg  out  WIDTH_CHANNEL_NUM_REG  to route Channel_Out_Num_REG
- route_next_reg  out  1  one-cycle clear pulse to route Next_Reg
- route_start  out  1  one-cycle start pulse to route Start
- route_complete  in  1  route Route_Complete
- beat_fire  in  1  route M_Valid & M_Ready
- busy  out  1  high in every state except IDLE
- done_pulse  out  1  layer completed OK
- err_pulse  out  1  layer aborted
- err_code  out  2  0 none, 1 bad descriptor, 2 beat overrun, 3 timeout
- layer_cnt  out  WIDTH_LAYER_CNT  completed layers, wraps

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - All outputs are registered.
  - On reset: state = IDLE; route_row_reg = 0, route_ch_reg = 0, route_next_reg = 0, route_start = 0, done_pulse = 0, err_pulse = 0, err_code = 0, layer_cnt = 0, busy = 0.
  - cmd_ready = 1 in IDLE, so cmd_ready reads 1 after reset.
  - Reset mid-layer aborts immediately. No pulse is emitted.
- States: IDLE, CHECK, CLEAR, START, RUN, DONE, ERR.
- IDLE:
  - cmd_ready = 1 (combinational from state).
  - On cmd_valid & cmd_ready: latch cmd_row into route_row_reg and cmd_ch into route_ch_reg, clear err_code, go to CHECK.
  - route_row_reg and route_ch_reg hold stable until the next accepted command.
- CHECK (1 cycle): go to ERR with code 1 if any of the following hold, else go to CLEAR:
  - row == 0
  - ch[4:0] != 0
  - ch < 32
- CLEAR: route_next_reg = 1 for exactly this cycle. Next state is START.
- START:
  - route_start = 1 for exactly this cycle.
  - expected = row * row * (ch >> 5), width 2*WIDTH_FEATURE_SIZE + WIDTH_CHANNEL_NUM_REG - 5.
  - Clear beat_cnt, cmpl_seen and idle_cnt. Next state is RUN.
- RUN:
  - Each beat_fire increments beat_cnt.
  - route_complete sets sticky cmpl_seen. The flag is also honoured in the same cycle it arrives.
  - If (beat_cnt + beat_fire) == expected and (cmpl_seen | route_complete): go to DONE.
  - If beat_fire occurs while beat_cnt == expected: go to ERR, code 2.
  - idle_cnt increments on cycles without beat_fire and resets on beat_fire. At idle_cnt == TIMEOUT_CYCLES - 1 with no beat: go to ERR, code 3.
  - Priority when conditions coincide: code 2 > DONE > code 3.
- DONE: done_pulse = 1 for one cycle; layer_cnt += 1, wrapping to 0 at all-ones. Next state is IDLE.
- ERR:
  - err_pulse = 1 for one cycle.
  - route_next_reg = 1 in the same cycle to flush the route's output counters.
  - err_code holds until the next command is accepted. Next state is IDLE.
- route_complete and beat_fire are ignored outside RUN.
- Back-to-back commands: the earliest acceptance is the cycle after DONE/ERR. Minimum overhead per layer is 5 cycles outside RUN.

Test Plan:
- Nominal: row=4, ch=64 → one Next_Reg pulse, then Start the next cycle; expected=32. Drive 32 beats with route_complete on the 32nd → done_pulse 1 cycle after, layer_cnt=1, err_pulse never.
- Bad descriptors: ch=48, then ch=16, then row=0 → each gives err_pulse with err_code=1, no route_start, layer_cnt unchanged.
- Backpressure: row=2, ch=32 (expected 4), beats spaced 10 cycles, route_complete arriving before the 4th beat → DONE only after the 4th beat.
- Overrun: row=1, ch=32 (expected 1), hold route_complete low, 2 beats → err_code=2, route_next_reg pulses in ERR.
- Timeout: TIMEOUT_CYCLES=16, Start then no beats → err_pulse 16 cycles after RUN entry, err_code=3. The next valid command clears err_code to 0.
- Reset mid-RUN after 3 beats → all outputs at reset values the next cycle, cmd_ready=1, no done/err pulse. layer_cnt wraps 255→0 after 256 nominal layers.

Source files
------------

// File: rtl/route_sched_if.sv
// Handshake and control bundle between the layer front end, the route block and route_sched.
// The slave modport is the sequencer's view; master is the driving environment.
interface route_sched_if #(
    parameter int WIDTH_FEATURE_SIZE    = 12,
    parameter int WIDTH_CHANNEL_NUM_REG = 11,
    parameter int WIDTH_LAYER_CNT       = 8
);
    logic                             cmd_valid;
    logic                             cmd_ready;
    logic [WIDTH_FEATURE_SIZE-1:0]    cmd_row;
    logic [WIDTH_CHANNEL_NUM_REG-1:0] cmd_ch;
    logic [WIDTH_FEATURE_SIZE-1:0]    route_row_reg;
    logic [WIDTH_CHANNEL_NUM_REG-1:0] route_ch_reg;
    logic                             route_next_reg;
    logic                             route_start;
    logic                             route_complete;
    logic                             beat_fire;
    logic                             busy;
    logic                             done_pulse;
    logic                             err_pulse;
    logic [1:0]                       err_code;
    logic [WIDTH_LAYER_CNT-1:0]       layer_cnt;

    modport master (
        output cmd_valid, cmd_row, cmd_ch, route_complete, beat_fire,
        input  cmd_ready, route_row_reg, route_ch_reg, route_next_reg, route_start,
               busy, done_pulse, err_pulse, err_code, layer_cnt
    );

    modport slave (
        input  cmd_valid, cmd_row, cmd_ch, route_complete, beat_fire,
        output cmd_ready, route_row_reg, route_ch_reg, route_next_reg, route_start,
               busy, done_pulse, err_pulse, err_code, layer_cnt
    );
endinterface

// File: rtl/route_sched.sv
// Per-layer sequencer for the route datapath: validates a descriptor, pulses Next_Reg/Start,
// counts output beats until completion, and reports done or an error code.
module route_sched #(
    parameter int WIDTH_FEATURE_SIZE    = 12,
    parameter int WIDTH_CHANNEL_NUM_REG = 11,
    parameter int TIMEOUT_CYCLES        = 65535,
    parameter int WIDTH_LAYER_CNT       = 8
) (
    input  logic          clk,
    input  logic          rst,
    route_sched_if.slave  bus
);
    localparam int EXP_W = 2 * WIDTH_FEATURE_SIZE + WIDTH_CHANNEL_NUM_REG - 5;
    localparam int IDW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_CLEAR, S_START, S_RUN, S_DONE, S_ERR
    } state_e;

    state_e                           state_q, state_d;
    logic [WIDTH_FEATURE_SIZE-1:0]    row_q, row_d;
    logic [WIDTH_CHANNEL_NUM_REG-1:0] ch_q, ch_d;
    logic [EXP_W-1:0]                 expected_q, expected_d;
    logic [EXP_W-1:0]                 beat_cnt_q, beat_cnt_d;
    logic [EXP_W-1:0]                 beat_sum;
    logic                             cmpl_seen_q, cmpl_seen_d;
    logic [IDW-1:0]                   idle_cnt_q, idle_cnt_d;
    logic                             next_reg_q, next_reg_d;
    logic                             start_q, start_d;
    logic                             done_q, done_d;
    logic                             err_q, err_d;
    logic [1:0]                       err_code_q, err_code_d;
    logic [WIDTH_LAYER_CNT-1:0]       layer_cnt_q, layer_cnt_d;
    logic                             busy_q, busy_d;

    assign beat_sum = beat_cnt_q + EXP_W'(bus.beat_fire);

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        ch_d        = ch_q;
        expected_d  = expected_q;
        beat_cnt_d  = beat_cnt_q;
        cmpl_seen_d = cmpl_seen_q;
        idle_cnt_d  = idle_cnt_q;
        err_code_d  = err_code_q;
        layer_cnt_d = layer_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    row_d      = bus.cmd_row;
                    ch_d       = bus.cmd_ch;
                    err_code_d = 2'd0;
                    state_d    = S_CHECK;
                end
            end
            S_CHECK: begin
                if (row_q == '0 || ch_q[4:0] != '0 ||
                    ch_q < WIDTH_CHANNEL_NUM_REG'(32)) begin
                    err_code_d = 2'd1;
                    state_d    = S_ERR;
                end else begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: state_d = S_START;
            S_START: begin
                // Each output beat carries 32 channels of one pixel.
                expected_d  = EXP_W'(row_q) * EXP_W'(row_q) * EXP_W'(ch_q >> 5);
                beat_cnt_d  = '0;
                cmpl_seen_d = 1'b0;
                idle_cnt_d  = '0;
                state_d     = S_RUN;
            end
            S_RUN: begin
                beat_cnt_d  = beat_sum;
                cmpl_seen_d = cmpl_seen_q | bus.route_complete;
                idle_cnt_d  = bus.beat_fire ? '0 : idle_cnt_q + IDW'(1);
                if (bus.beat_fire && beat_cnt_q == expected_q) begin
                    err_code_d = 2'd2;
                    state_d    = S_ERR;
                end else if (beat_sum == expected_q && (cmpl_seen_q || bus.route_complete)) begin
                    layer_cnt_d = layer_cnt_q + WIDTH_LAYER_CNT'(1);
                    state_d     = S_DONE;
                end else if (!bus.beat_fire && idle_cnt_q == IDW'(TIMEOUT_CYCLES - 1)) begin
                    err_code_d = 2'd3;
                    state_d    = S_ERR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Pulses are decoded from the next state so the flops line up with the state.
        next_reg_d = (state_d == S_CLEAR) || (state_d == S_ERR);
        start_d    = (state_d == S_START);
        done_d     = (state_d == S_DONE);
        err_d      = (state_d == S_ERR);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            ch_q        <= '0;
            expected_q  <= '0;
            beat_cnt_q  <= '0;
            cmpl_seen_q <= 1'b0;
            idle_cnt_q  <= '0;
            next_reg_q  <= 1'b0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'd0;
            layer_cnt_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            ch_q        <= ch_d;
            expected_q  <= expected_d;
            beat_cnt_q  <= beat_cnt_d;
            cmpl_seen_q <= cmpl_seen_d;
            idle_cnt_q  <= idle_cnt_d;
            next_reg_q  <= next_reg_d;
            start_q     <= start_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            layer_cnt_q <= layer_cnt_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.cmd_ready      = (state_q == S_IDLE);
    assign bus.route_row_reg  = row_q;
    assign bus.route_ch_reg   = ch_q;
    assign bus.route_next_reg = next_reg_q;
    assign bus.route_start    = start_q;
    assign bus.busy           = busy_q;
    assign bus.done_pulse     = done_q;
    assign bus.err_pulse      = err_q;
    assign bus.err_code       = err_code_q;
    assign bus.layer_cnt      = layer_cnt_q;
endmodule
